alct_loopback_prbs: RTL and testbench

//  ALCT<->TMB link test block. Decodes the 4-bit sequencer command into sync modes and drives the
//  two time-multiplexed TX test words. Modes: fixed 1010/0101 patterns, RX->TX echo, segment capture.

---
 rtl/alct_loopback_prbs_pkg.sv | 41 ++++
 rtl/alct_loopback_prbs_if.sv | 27 ++
 rtl/alct_loopback_prbs_lfsr.sv | 24 ++
 rtl/alct_loopback_prbs.sv | 148 ++++++++++++++
 tb/tb_alct_loopback_prbs.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alct_loopback_prbs_pkg.sv
// Shared constants, PRBS seeds/taps and the link-test mode decode.
package alct_lb_pkg;

  localparam int unsigned LFSR_W = 28;
  localparam int unsigned TAP_A  = 28;
  localparam int unsigned TAP_B  = 25;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LFSR_W-1:0] SEED1 = 28'h0000001;
  localparam logic [LFSR_W-1:0] SEED2 = 28'h8F3A5C1;

  typedef enum logic [2:0] {
    LB_IDLE,
    LB_TEO,
    LB_RLOOP,
    LB_SEG0,
    LB_SEG1,
    LB_SEG2,
    LB_PRBS
  } lb_mode_e;

  // teo wins over rloop, which wins over the address-selected modes
  function automatic lb_mode_e decode_mode(input logic [3:0] cmd);
    lb_mode_e m;
    m = LB_IDLE;
    if (cmd[2] | cmd[0]) begin
      if (cmd[2] & cmd[0])  m = LB_TEO;
      else if (cmd[2])      m = LB_RLOOP;
      else begin
        case ({cmd[3], cmd[1]})
          2'd0:    m = LB_SEG0;
          2'd1:    m = LB_SEG1;
          2'd2:    m = LB_SEG2;
          default: m = LB_PRBS;
        endcase
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/alct_loopback_prbs_if.sv
// Sequencer command, RX test words and TX/status outputs of the link-test block.
interface alct_loopback_prbs_if #(
  parameter int unsigned TXW = 28,
  parameter int unsigned RXW = 10
);
  import alct_lb_pkg::*;

  logic [3:0]       seq_cmd;
  logic [RXW-1:0]   rx_1st;
  logic [RXW-1:0]   rx_2nd;
  logic [TXW-1:0]   tx_1st;
  logic [TXW-1:0]   tx_2nd;
  logic             sync_mode;
  logic [CNT_W-1:0] prbs_err_cnt;
  logic             prbs_locked;

  modport master (
    output seq_cmd, rx_1st, rx_2nd,
    input  tx_1st, tx_2nd, sync_mode, prbs_err_cnt, prbs_locked
  );

  modport slave (
    input  seq_cmd, rx_1st, rx_2nd,
    output tx_1st, tx_2nd, sync_mode, prbs_err_cnt, prbs_locked
  );

endinterface

// File: rtl/alct_loopback_prbs_lfsr.sv
// 28-bit Fibonacci LFSR, x^28+x^25+1, shifting toward the MSB.
module alct_prbs_lfsr
  import alct_lb_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb    = r_state[TAP_A-1] ^ r_state[TAP_B-1];
  assign o_state = r_state;

  always_ff @(posedge i_clock) begin
    if (i_reset)   r_state <= SEED;
    else if (i_en) r_state <= {r_state[LFSR_W-2:0], w_fb};
  end

endmodule

// File: rtl/alct_loopback_prbs.sv
// ALCT<->TMB link test: command decode, TX test-word mux, PRBS source and delayed-echo checker.
module alct_loopback_prbs
  import alct_lb_pkg::*;
#(
  parameter int unsigned TXW    = 28,
  parameter int unsigned RXW    = 10,
  parameter int unsigned LAT    = 4,
  parameter int unsigned LOCK_N = 64
) (
  input logic                 i_clock,
  input logic                 i_reset,
  alct_loopback_prbs_if.slave io_lb
);

  localparam int unsigned SEG2_W = TXW - 2 * RXW;
  localparam int unsigned FILL_W = $clog2(LAT + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_N + 1);
  localparam logic [TXW-1:0] TEO1 = TXW'({(TXW/2){2'b10}});
  localparam logic [TXW-1:0] TEO2 = TXW'({(TXW/2){2'b01}});

  lb_mode_e          w_mode;
  logic              w_prbs;
  logic              w_entry;
  logic              w_cmp_en;
  logic              w_miss;
  logic [LFSR_W-1:0] w_lfsr1;
  logic [LFSR_W-1:0] w_lfsr2;
  logic [TXW-1:0]    w_tx1_nxt;
  logic [TXW-1:0]    w_tx2_nxt;

  logic [TXW-1:0]    r_tx1;
  logic [TXW-1:0]    r_tx2;
  logic [RXW-1:0]    r_dl1 [LAT];
  logic [RXW-1:0]    r_dl2 [LAT];
  logic [FILL_W-1:0] r_fill;
  logic [RUN_W-1:0]  r_good;
  logic [CNT_W-1:0]  r_err;
  logic              r_locked;
  logic              r_prbs_q;

  assign w_mode  = decode_mode(io_lb.seq_cmd);
  assign w_prbs  = (w_mode == LB_PRBS);
  assign w_entry = w_prbs & ~r_prbs_q;

  alct_prbs_lfsr #(.SEED(SEED1)) u_lfsr1 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (w_prbs),
    .o_state (w_lfsr1)
  );

  alct_prbs_lfsr #(.SEED(SEED2)) u_lfsr2 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (w_prbs),
    .o_state (w_lfsr2)
  );

  // Next TX word for one half; unselected segments keep their value
  function automatic logic [TXW-1:0] tx_next(input lb_mode_e m, input logic [TXW-1:0] cur,
                                             input logic [RXW-1:0] rx, input logic [TXW-1:0] teo,
                                             input logic [TXW-1:0] prbs);
    logic [TXW-1:0] t;
    t = cur;
    case (m)
      LB_TEO:   t = teo;
      LB_RLOOP: t = {rx[SEG2_W-1:0], ~rx, rx};
      LB_SEG0:  t[RXW-1:0] = rx;
      LB_SEG1:  t[2*RXW-1:RXW] = rx;
      LB_SEG2:  t[TXW-1:2*RXW] = rx[SEG2_W-1:0];
      LB_PRBS:  t = prbs;
      default:  t = cur;
    endcase
    return t;
  endfunction

  assign w_tx1_nxt = tx_next(w_mode, r_tx1, io_lb.rx_1st, TEO1, TXW'(w_lfsr1));
  assign w_tx2_nxt = tx_next(w_mode, r_tx2, io_lb.rx_2nd, TEO2, TXW'(w_lfsr2));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx1 <= '0;
      r_tx2 <= '0;
    end else begin
      r_tx1 <= w_tx1_nxt;
      r_tx2 <= w_tx2_nxt;
    end
  end

  // Delay line tracks what was on the wire; entry LAT-1 lines up with the current rx
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_dl1[i] <= '0;
        r_dl2[i] <= '0;
      end
    end else begin
      r_dl1[0] <= r_tx1[RXW-1:0];
      r_dl2[0] <= r_tx2[RXW-1:0];
      for (int i = 1; i < LAT; i++) begin
        r_dl1[i] <= r_dl1[i-1];
        r_dl2[i] <= r_dl2[i-1];
      end
    end
  end

  assign w_cmp_en = w_prbs & (r_fill == FILL_W'(LAT));
  assign w_miss   = (io_lb.rx_1st != r_dl1[LAT-1]) | (io_lb.rx_2nd != r_dl2[LAT-1]);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prbs_q <= 1'b0;
      r_fill   <= '0;
      r_good   <= '0;
      r_err    <= '0;
      r_locked <= 1'b0;
    end else begin
      r_prbs_q <= w_prbs;
      if (!w_prbs) begin
        r_fill <= '0;
      end else if (w_entry) begin
        r_fill   <= '0;
        r_good   <= '0;
        r_err    <= '0;
        r_locked <= 1'b0;
      end else begin
        if (r_fill != FILL_W'(LAT)) r_fill <= r_fill + FILL_W'(1);
        if (w_cmp_en) begin
          if (w_miss) begin
            if (r_err != {CNT_W{1'b1}}) r_err <= r_err + CNT_W'(1);
            r_good   <= '0;
            r_locked <= 1'b0;
          end else begin
            if (r_good != RUN_W'(LOCK_N)) r_good <= r_good + RUN_W'(1);
            if (r_good >= RUN_W'(LOCK_N - 1)) r_locked <= 1'b1;
          end
        end
      end
    end
  end

  assign io_lb.tx_1st        = r_tx1;
  assign io_lb.tx_2nd        = r_tx2;
  assign io_lb.sync_mode     = io_lb.seq_cmd[2] | io_lb.seq_cmd[0];
  assign io_lb.prbs_err_cnt  = r_err;
  assign io_lb.prbs_locked   = r_locked;

endmodule

// File: tb/tb_alct_loopback_prbs.sv
// Directed bench for alct_loopback_prbs with a cycle-level behavioural model and literal anchors.
module tb_alct_loopback_prbs;

  localparam int unsigned TXW    = 28;
  localparam int unsigned RXW    = 10;
  localparam int unsigned LAT    = 4;
  localparam int unsigned LOCK_N = 64;
  localparam logic [3:0]  C_PRBS = 4'b1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alct_loopback_prbs_if #(.TXW(TXW), .RXW(RXW)) bus ();

  alct_loopback_prbs #(.TXW(TXW), .RXW(RXW), .LAT(LAT), .LOCK_N(LOCK_N)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_lb   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [TXW-1:0] m_tx1, m_tx2;
  logic [27:0]    m_l1, m_l2;
  int             m_err, m_good, m_run;
  logic           m_locked;
  logic [TXW-1:0] vis1 [$];
  logic [TXW-1:0] vis2 [$];

  function automatic logic [27:0] lfsr_step(input logic [27:0] s);
    logic [27:0] n;
    n = s << 1;
    n[0] = s[27] ^ s[24];
    return n;
  endfunction

  function automatic logic [TXW-1:0] rloop_word(input logic [RXW-1:0] rx);
    logic [TXW-1:0] w;
    w = '0;
    for (int i = 0; i < TXW; i++) begin
      if (i < RXW)          w[i] = rx[i];
      else if (i < 2 * RXW) w[i] = ~rx[i - RXW];
      else                  w[i] = rx[i - 2 * RXW];
    end
    return w;
  endfunction

  function automatic logic [TXW-1:0] seg_write(input logic [TXW-1:0] cur, input logic [RXW-1:0] rx,
                                               input int seg);
    logic [TXW-1:0] w;
    int b;
    w = cur;
    for (int i = 0; i < RXW; i++) begin
      b = seg * RXW + i;
      if (b < TXW) w[b] = rx[i];
    end
    return w;
  endfunction

  function automatic logic [TXW-1:0] alt_word(input bit odd_ones);
    logic [TXW-1:0] w;
    w = '0;
    for (int i = 0; i < TXW / 2; i++) begin
      if (odd_ones) w[2 * i + 1] = 1'b1;
      else          w[2 * i] = 1'b1;
    end
    return w;
  endfunction

  // Word on the wire LAT cycles before the current one, low RXW bits
  function automatic logic [RXW-1:0] past(input bit second, input int back);
    logic [TXW-1:0] t;
    if (vis1.size() <= back) return '0;
    t = second ? vis2[vis2.size() - 1 - back] : vis1[vis1.size() - 1 - back];
    return t[RXW-1:0];
  endfunction

  logic [3:0]     mc;
  bit             m_sync, m_teo, m_rl, m_prbs;
  int             m_adr;
  logic [TXW-1:0] n1, n2;

  always @(posedge clk) begin
    mc = bus.seq_cmd;
    if (rst) begin
      m_tx1 = '0; m_tx2 = '0;
      m_l1 = 28'h0000001; m_l2 = 28'h8F3A5C1;
      m_err = 0; m_good = 0; m_run = 0; m_locked = 1'b0;
      vis1.delete(); vis2.delete();
    end else begin
      m_sync = mc[2] | mc[0];
      m_teo  = mc[2] & mc[0];
      m_rl   = mc[2] & ~mc[0];
      m_adr  = {mc[3], mc[1]};
      m_prbs = m_sync && !m_teo && !m_rl && (m_adr == 3);
      n1 = m_tx1; n2 = m_tx2;
      if (m_prbs) begin
        if (m_run == 0) begin
          m_err = 0; m_good = 0; m_locked = 1'b0;
        end else if (m_run >= LAT + 1) begin
          if (bus.rx_1st != past(1'b0, LAT) || bus.rx_2nd != past(1'b1, LAT)) begin
            if (m_err < 65535) m_err = m_err + 1;
            m_good = 0; m_locked = 1'b0;
          end else begin
            if (m_good < LOCK_N) m_good = m_good + 1;
            if (m_good >= LOCK_N) m_locked = 1'b1;
          end
        end
        if (m_run < 1000000) m_run = m_run + 1;
        n1 = TXW'(m_l1); n2 = TXW'(m_l2);
        m_l1 = lfsr_step(m_l1); m_l2 = lfsr_step(m_l2);
      end else begin
        m_run = 0;
        if (m_teo) begin
          n1 = alt_word(1'b1); n2 = alt_word(1'b0);
        end else if (m_rl) begin
          n1 = rloop_word(bus.rx_1st); n2 = rloop_word(bus.rx_2nd);
        end else if (m_sync) begin
          n1 = seg_write(m_tx1, bus.rx_1st, m_adr);
          n2 = seg_write(m_tx2, bus.rx_2nd, m_adr);
        end
      end
      m_tx1 = n1; m_tx2 = n2;
      vis1.push_back(m_tx1); vis2.push_back(m_tx2);
      if (vis1.size() > 32) begin
        void'(vis1.pop_front());
        void'(vis2.pop_front());
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("tx_1st", 64'(bus.tx_1st), 64'(m_tx1));
    check("tx_2nd", 64'(bus.tx_2nd), 64'(m_tx2));
    check("prbs_err_cnt", 64'(bus.prbs_err_cnt), 64'(m_err));
    check("prbs_locked", 64'(bus.prbs_locked), 64'(m_locked));
    check("sync_mode", 64'(bus.sync_mode), 64'(bus.seq_cmd[2] | bus.seq_cmd[0]));
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [3:0] c, input logic [RXW-1:0] a, input logic [RXW-1:0] b);
    bus.seq_cmd = c;
    bus.rx_1st  = a;
    bus.rx_2nd  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic echo(input int n, input logic [RXW-1:0] flip2);
    for (int i = 0; i < n; i++) apply(C_PRBS, past(1'b0, LAT), past(1'b1, LAT) ^ flip2);
  endtask

  logic [TXW-1:0] exp_w;

  initial begin
    bus.seq_cmd = 4'b0000;
    bus.rx_1st  = '0;
    bus.rx_2nd  = '0;
    rst = 1'b1;
    apply(4'b0000, '0, '0);
    apply(4'b0000, '0, '0);
    check("reset_tx_1st", 64'(bus.tx_1st), 64'h0);
    check("reset_err", 64'(bus.prbs_err_cnt), 64'h0);
    check("reset_locked", 64'(bus.prbs_locked), 64'h0);
    rst = 1'b0;

    apply(4'b0101, '0, '0);
    check("teo_tx_1st", 64'(bus.tx_1st), 64'h0AAAAAAA);
    check("teo_tx_2nd", 64'(bus.tx_2nd), 64'h05555555);
    check("teo_sync", 64'(bus.sync_mode), 64'h1);

    apply(4'b0100, 10'h3A5, 10'h0F0);
    exp_w = {8'hA5, 10'h05A, 10'h3A5};
    check("rloop_tx_1st", 64'(bus.tx_1st), 64'(exp_w));
    apply(4'b0000, 10'h111, 10'h222);
    check("idle_hold", 64'(bus.tx_1st), 64'(exp_w));
    check("idle_sync", 64'(bus.sync_mode), 64'h0);

    apply(4'b0001, 10'h155, 10'h001);
    apply(4'b0011, 10'h2AA, 10'h002);
    apply(4'b1001, 10'h0F0, 10'h003);
    exp_w = {8'hF0, 10'h2AA, 10'h155};
    check("seg_tx_1st", 64'(bus.tx_1st), 64'(exp_w));
    exp_w = {8'h03, 10'h002, 10'h001};
    check("seg_tx_2nd", 64'(bus.tx_2nd), 64'(exp_w));

    echo(1, '0);
    check("prbs_first_1st", 64'(bus.tx_1st), 64'h0000001);
    check("prbs_first_2nd", 64'(bus.tx_2nd), 64'h8F3A5C1);
    echo(1, '0);
    check("prbs_second_1st", 64'(bus.tx_1st), 64'h0000002);
    check("prbs_second_2nd", 64'(bus.tx_2nd), 64'h1E74B83);
    echo(66, '0);
    check("lock_not_yet", 64'(bus.prbs_locked), 64'h0);
    echo(1, '0);
    check("lock_at_68", 64'(bus.prbs_locked), 64'h1);
    check("lock_err_zero", 64'(bus.prbs_err_cnt), 64'h0);

    echo(5, '0);
    echo(3, 10'h001);
    check("flip_err", 64'(bus.prbs_err_cnt), 64'd3);
    check("flip_unlock", 64'(bus.prbs_locked), 64'h0);
    echo(63, '0);
    check("relock_not_yet", 64'(bus.prbs_locked), 64'h0);
    echo(1, '0);
    check("relock", 64'(bus.prbs_locked), 64'h1);

    for (int i = 0; i < 70000; i++) apply(C_PRBS, '0, '0);
    check("err_saturated", 64'(bus.prbs_err_cnt), 64'hFFFF);

    rst = 1'b1;
    apply(C_PRBS, '0, '0);
    check("midreset_tx_1st", 64'(bus.tx_1st), 64'h0);
    check("midreset_tx_2nd", 64'(bus.tx_2nd), 64'h0);
    check("midreset_err", 64'(bus.prbs_err_cnt), 64'h0);
    check("midreset_locked", 64'(bus.prbs_locked), 64'h0);
    rst = 1'b0;
    apply(C_PRBS, '0, '0);
    check("reseed_1st", 64'(bus.tx_1st), 64'h0000001);
    check("reseed_2nd", 64'(bus.tx_2nd), 64'h8F3A5C1);
    apply(4'b0000, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
